// File: rtl/datapath.sv
// Multicycle processor datapath: 16-entry register file, function unit and unified 64-word memory.
// Define DATAPATH_R0_ZERO_EN to hardwire R0 to zero (writes to R0 ignored, reads return 0).
module datapath #(
  parameter int DW = 16,
  parameter int AW = 6
) (
  input  logic          clk_main,
  input  logic          reset,
  input  logic [3:0]    DR,
  input  logic [3:0]    SA,
  input  logic [3:0]    SB,
  input  logic [3:0]    FS,
  input  logic          MB,
  input  logic          MM,
  input  logic          MD,
  input  logic          MW,
  input  logic          RW,
  input  logic [AW-1:0] PC,
  output logic          Z,
  output logic [3:0]    BusA,
  output logic [DW-1:0] InstructIn
);

  localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

  logic [DW-1:0] regs [16];
  logic [DW-1:0] mem  [2**AW];

  logic [DW-1:0] a_bus;
  logic [DW-1:0] b_reg;
  logic [DW-1:0] b_bus;
  logic [DW-1:0] f;
  logic [DW-1:0] d_bus;
  logic [DW-1:0] mem_data;
  logic [AW-1:0] data_addr;

  always_comb begin
    a_bus = regs[SA];
    b_reg = regs[SB];
`ifdef DATAPATH_R0_ZERO_EN
    if (SA == 4'd0) a_bus = '0;
    if (SB == 4'd0) b_reg = '0;
`endif
  end

  assign b_bus = MB ? {{(DW-4){1'b0}}, SB} : b_reg;

  // Function unit; all arithmetic wraps modulo 2^DW with the carry discarded.
  always_comb begin
    f = '0;
    case (FS)
      4'b0000: f = a_bus;
      4'b0001: f = a_bus + ONE;
      4'b0010: f = a_bus + b_bus;
      4'b0011: f = a_bus + b_bus + ONE;
      4'b0100: f = a_bus + ~b_bus;
      4'b0101: f = a_bus + ~b_bus + ONE;
      4'b0110: f = a_bus - ONE;
      4'b0111: f = a_bus;
      4'b1000: f = a_bus & b_bus;
      4'b1001: f = a_bus | b_bus;
      4'b1010: f = a_bus ^ b_bus;
      4'b1011: f = ~a_bus;
      4'b1100: f = b_bus;
      4'b1101: f = {1'b0, b_bus[DW-1:1]};
      4'b1110: f = {b_bus[DW-2:0], 1'b0};
      default: f = '0;
    endcase
  end

  assign Z          = (f == '0);
  assign BusA       = a_bus[3:0];
  assign data_addr  = MM ? PC : a_bus[AW-1:0];
  assign mem_data   = mem[data_addr];
  assign InstructIn = mem[PC];
  assign d_bus      = MD ? mem_data : f;

  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (RW) begin
`ifdef DATAPATH_R0_ZERO_EN
      if (DR != 4'd0) regs[DR] <= d_bus;
`else
      regs[DR] <= d_bus;
`endif
    end
  end

  // Memory keeps its contents through reset; reset only blocks writes while it is held low.
  always_ff @(posedge clk_main or negedge reset) begin
    if (reset) begin
      if (MW) mem[data_addr] <= b_bus;
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: stimulus queues hand-computed expectations, a negedge monitor compares.
// Register contents are observed by storing them to mem[40] and reading InstructIn with PC=40.
module tb_datapath;

  localparam int DW = 16;
  localparam int AW = 6;

  logic          clk_main = 1'b0;
  logic          reset = 1'b0;
  logic [3:0]    DR, SA, SB, FS;
  logic          MB, MM, MD, MW, RW;
  logic [AW-1:0] PC;
  logic          Z;
  logic [3:0]    BusA;
  logic [DW-1:0] InstructIn;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic          chk_z;
    logic          chk_busa;
    logic          chk_instr;
    logic          z;
    logic [3:0]    busa;
    logic [DW-1:0] instr;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  logic [DW-1:0] fs_exp [16] = '{16'h0007, 16'h0008, 16'h0010, 16'h0011,
                                 16'hFFFD, 16'hFFFE, 16'h0006, 16'h0007,
                                 16'h0001, 16'h000F, 16'h000E, 16'hFFF8,
                                 16'h0009, 16'h0004, 16'h0012, 16'h0000};

  datapath #(.DW(DW), .AW(AW)) dut (
    .clk_main(clk_main), .reset(reset),
    .DR(DR), .SA(SA), .SB(SB), .FS(FS),
    .MB(MB), .MM(MM), .MD(MD), .MW(MW), .RW(RW),
    .PC(PC), .Z(Z), .BusA(BusA), .InstructIn(InstructIn)
  );

  always #5 clk_main = ~clk_main;

  initial begin
    #100000;
    $display("[TB] FAIL timeout: bench did not finish within the time limit");
    $fatal(1, "[TB] timeout");
  end

  // Monitor: every queued expectation is compared at the falling edge after it was issued.
  always @(negedge clk_main) begin
    while (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      if (e.chk_z) begin
        checks++;
        if (Z !== e.z) begin
          failures++;
          $display("[TB] FAIL %s: Z got %0b expected %0b", n, Z, e.z);
        end
      end
      if (e.chk_busa) begin
        checks++;
        if (BusA !== e.busa) begin
          failures++;
          $display("[TB] FAIL %s: BusA got 0x%0h expected 0x%0h", n, BusA, e.busa);
        end
      end
      if (e.chk_instr) begin
        checks++;
        if (InstructIn !== e.instr) begin
          failures++;
          $display("[TB] FAIL %s: InstructIn got 0x%04h expected 0x%04h", n, InstructIn, e.instr);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] dr, input logic [3:0] sa, input logic [3:0] sb,
                               input logic [3:0] fs, input logic mb, input logic mm, input logic md,
                               input logic mw, input logic rw, input logic [AW-1:0] pc);
    @(posedge clk_main);
    #1;
    DR = dr; SA = sa; SB = sb; FS = fs;
    MB = mb; MM = mm; MD = md; MW = mw; RW = rw; PC = pc;
  endtask

  task automatic checkOutput(input string name, input logic cz, input logic cb, input logic ci,
                             input logic z, input logic [3:0] busa, input logic [DW-1:0] instr);
    exp_t e;
    e.chk_z = cz; e.chk_busa = cb; e.chk_instr = ci;
    e.z = z; e.busa = busa; e.instr = instr;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic op(input logic [3:0] dr, input logic [3:0] sa, input logic [3:0] sb,
                    input logic [3:0] fs, input logic mb);
    applyStimulus(dr, sa, sb, fs, mb, 1'b0, 1'b0, 1'b0, 1'b1, '0);
  endtask

  task automatic idle(input logic [3:0] sa, input logic [3:0] fs, input logic [AW-1:0] pc);
    applyStimulus(4'd0, sa, 4'd0, fs, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pc);
  endtask

  task automatic load_imm(input logic [3:0] dr, input logic [3:0] k);
    op(dr, 4'd0, k, 4'b1100, 1'b1);
  endtask

  task automatic shl4(input logic [3:0] r);
    repeat (4) op(r, 4'd0, r, 4'b1110, 1'b0);
  endtask

  task automatic add_imm(input logic [3:0] r, input logic [3:0] k);
    op(r, r, k, 4'b0010, 1'b1);
  endtask

  task automatic dump_reg(input string name, input logic [3:0] r, input logic [DW-1:0] exp_val);
    applyStimulus(4'd0, 4'd0, r, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd40);
    idle(4'd0, 4'b1111, 6'd40);
    checkOutput(name, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, exp_val);
  endtask

  initial begin
    DR = '0; SA = '0; SB = '0; FS = '0;
    MB = 0; MM = 0; MD = 0; MW = 0; RW = 0; PC = '0;

    // Reset behaviour
    idle(4'd3, 4'b0000, '0);
    checkOutput("reset_state", 1, 1, 0, 1'b1, 4'h0, '0);
    @(negedge clk_main);
    #1 reset = 1'b1;
    load_imm(4'd3, 4'd9);
    idle(4'd3, 4'b0000, '0);
    checkOutput("preload_r3", 1, 1, 0, 1'b0, 4'h9, '0);
    idle(4'd3, 4'b0000, '0);
    #1 reset = 1'b0;
    checkOutput("async_clear", 1, 1, 0, 1'b1, 4'h0, '0);
    applyStimulus(4'd3, 4'd3, 4'd7, 4'b1100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, '0);
    checkOutput("rw_in_reset_busa", 0, 1, 0, 1'b0, 4'h0, '0);
    idle(4'd3, 4'b0000, '0);
    reset = 1'b1;
    checkOutput("rw_blocked", 1, 1, 0, 1'b1, 4'h0, '0);
    applyStimulus(4'd3, 4'd0, 4'd5, 4'b1100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    #2 reset = 1'b0;
    idle(4'd3, 4'b0000, '0);
    reset = 1'b1;
    checkOutput("rst_same_cycle", 1, 1, 0, 1'b1, 4'h0, '0);

    // Load immediate and read-during-write
    applyStimulus(4'd3, 4'd3, 4'd5, 4'b1100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    checkOutput("rdw_old", 0, 1, 0, 1'b0, 4'h0, '0);
    idle(4'd3, 4'b0000, '0);
    checkOutput("load_imm", 1, 1, 0, 1'b0, 4'h5, '0);

    // Arithmetic
    load_imm(4'd1, 4'd7);
    load_imm(4'd2, 4'd9);
    op(4'd4, 4'd1, 4'd2, 4'b0010, 1'b0);
    idle(4'd4, 4'b0000, '0);
    checkOutput("add_busa", 1, 1, 0, 1'b0, 4'h0, '0);
    dump_reg("add_r4", 4'd4, 16'h0010);
    applyStimulus(4'd0, 4'd1, 4'd1, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("sub_self_zero", 1, 0, 0, 1'b1, 4'h0, '0);
    op(4'd7, 4'd0, 4'd0, 4'b0110, 1'b0);
    checkOutput("dec_r0_z", 1, 0, 0, 1'b0, 4'h0, '0);
    dump_reg("dec_r0", 4'd7, 16'hFFFF);

    // Full function table with A=7, B=9
    for (int i = 0; i < 16; i++) begin
      op(4'd8, 4'd1, 4'd2, 4'(i), 1'b0);
      checkOutput($sformatf("fs%0h_z", i), 1, 0, 0, (fs_exp[i] == 16'h0000), 4'h0, '0);
      dump_reg($sformatf("fs%0h_f", i), 4'd8, fs_exp[i]);
    end

    // Shifts and logic
    load_imm(4'd2, 4'd1);
    repeat (15) op(4'd2, 4'd0, 4'd2, 4'b1110, 1'b0);
    add_imm(4'd2, 4'd1);
    dump_reg("r2_8001", 4'd2, 16'h8001);
    op(4'd8, 4'd0, 4'd2, 4'b1110, 1'b0);
    dump_reg("shl", 4'd8, 16'h0002);
    op(4'd8, 4'd0, 4'd2, 4'b1101, 1'b0);
    dump_reg("shr", 4'd8, 16'h4000);
    load_imm(4'd9, 4'd15);
    shl4(4'd9);
    add_imm(4'd9, 4'd15);
    op(4'd8, 4'd9, 4'd0, 4'b1011, 1'b0);
    dump_reg("not_a", 4'd8, 16'hFF00);

    // Memory
    applyStimulus(4'd0, 4'd1, 4'd4, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    applyStimulus(4'd5, 4'd1, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd7);
    checkOutput("instr_pc7", 0, 0, 1, 1'b0, 4'h0, 16'h0010);
    dump_reg("md_load_r5", 4'd5, 16'h0010);
    load_imm(4'd11, 4'd4);
    shl4(4'd11);
    add_imm(4'd11, 4'd7);
    applyStimulus(4'd12, 4'd11, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, '0);
    dump_reg("addr_trunc", 4'd12, 16'h0010);
    applyStimulus(4'd0, 4'd0, 4'd9, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'd20);
    applyStimulus(4'd0, 4'd1, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd20);
    checkOutput("instr_mm_indep", 0, 0, 1, 1'b0, 4'h0, 16'h0009);
    applyStimulus(4'd6, 4'd0, 4'd0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'd20);
    dump_reg("mm_pc_load", 4'd6, 16'h0009);
    applyStimulus(4'd3, 4'd1, 4'd3, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, '0);
    idle(4'd0, 4'b0000, 6'd7);
    checkOutput("rw_mw_mem", 0, 0, 1, 1'b0, 4'h0, 16'h0005);
    dump_reg("rw_mw_reg", 4'd3, 16'h0010);

    // R0 behaviour under both builds
    load_imm(4'd13, 4'd1);
    shl4(4'd13);
    add_imm(4'd13, 4'd2);
    shl4(4'd13);
    add_imm(4'd13, 4'd3);
    shl4(4'd13);
    add_imm(4'd13, 4'd4);
    op(4'd0, 4'd13, 4'd0, 4'b0000, 1'b0);
    idle(4'd0, 4'b0000, '0);
`ifdef DATAPATH_R0_ZERO_EN
    checkOutput("r0_busa", 1, 1, 0, 1'b1, 4'h0, '0);
    dump_reg("r0_value", 4'd0, 16'h0000);
`else
    checkOutput("r0_busa", 1, 1, 0, 1'b0, 4'h4, '0);
    dump_reg("r0_value", 4'd0, 16'h1234);
`endif

    idle(4'd0, 4'b0000, '0);
    repeat (2) @(posedge clk_main);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/datapath.md
# datapath

Register file, function unit and unified 64-word memory of the multicycle processor; the direct downstream consumer of the control path. It takes the decoded register fields (DR, SA, SB), the function select FS and the mux/write strobes (MB, MM, MD, MW, RW) plus PC. It returns the Z flag, the low nibble of the A bus for PC jumps, and the instruction word at PC. All state updates occur on the rising edge of clk_main; all read paths are combinational.

## Interface
- DW, 16, data/register/memory word width
- AW, 6, memory address width; must equal PC width
- clk_main  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-low; clears the register file
- DR  in  4  destination register index
- SA  in  4  A-bus source register index
- SB  in  4  B-bus source register index; also the constant when MB=1
- FS  in  4  function-unit select
- MB  in  1  B-bus select: 0 = reg[SB], 1 = zero-extended SB constant
- MM  in  1  memory address select: 0 = A[AW-1:0], 1 = PC
- MD  in  1  D-bus select: 0 = function output F, 1 = memory read data
- MW  in  1  memory write enable
- RW  in  1  register write enable
- PC  in  AW  program counter
- Z  out  1  1 when F == 0
- BusA  out  4  A[3:0], jump offset/target into the program counter
- InstructIn  out  DW  mem[PC], fed to the instruction register

## Operation
- Register file: 16 × DW. Reads of A and B are combinational. Write: if RW=1 at the rising edge, reg[DR] <= D.
- Read-during-write returns the old value until the edge.
- B bus: MB ? {zeros, SB} : reg[SB].
- Function unit (F, mod 2^DW, carry discarded):
  - 0000 A; 0001 A+1; 0010 A+B; 0011 A+B+1
  - 0100 A+~B; 0101 A+~B+1 (A−B); 0110 A−1; 0111 A
  - 1000 A&B; 1001 A|B; 1010 A^B; 1011 ~A
  - 1100 B; 1101 B>>1 (logical, 0 in); 1110 B<<1 (0 in); 1111 zero
- Z = (F == 0), combinational and unregistered; the control logic samples it in its branch state.
- Memory: 2^AW × DW with two read ports and one write port.
  - Data port address is MM ? PC : A[AW-1:0]; read is combinational.
  - InstructIn = mem[PC] on a dedicated read port, independent of MM.
  - Write: if MW=1 at the edge, mem[data address] <= B bus.
- D bus: MD ? memory data : F.
- RW and MW may both be 1 in one cycle: both writes use pre-edge values.

## Timing
- Reset asserted (low): every register goes to 0 immediately, regardless of the clock. Memory contents are untouched.
- While reset is low, RW and MW writes are blocked. Then BusA=0 and Z=1 whenever FS selects A, B or zero.
- Reset deasserted: the first write can occur on the next rising edge.
- If reset asserts in the same cycle as an RW pulse, the register stays 0.
- Latency: register or memory write is visible on the read paths 1 cycle after the strobe edge; reads have 0 cycles of latency.
- PC wrap and address wrap are inherent to AW bits; an A value ≥ 2^AW is truncated.
- No handshake: the control path holds its strobes for exactly the cycle of the intended write.

## Configuration
- DATAPATH_R0_ZERO_EN defined: R0 is hardwired to 0. RW with DR=0 is ignored, and reads of R0 return 0.
- Not defined: R0 is an ordinary register.

## Test plan
- Reset: preload R3 via RW, then pulse reset low mid-cycle -> R3=0 at once; SA=3, FS=0000 -> BusA=0, Z=1.
- Load immediate: MB=1, SB=5, FS=1100, DR=3, RW=1, one edge -> R3=0x0005; SA=3 -> BusA=5, Z=0.
- Arithmetic: R1=7, R2=9, SA=1, SB=2, FS=0010, DR=4 -> R4=0x0010. Then FS=0101 with SA=SB=1 -> F=0, Z=1. Then FS=0110 on R0=0 -> F=0xFFFF.
- Shifts/logic: R2=0x8001. FS=1110 -> F=0x0002. FS=1101 -> F=0x4000. FS=1011 with A=0x00FF -> F=0xFF00.
- Memory: R1=0x0007, R4=0x0010, MM=0, SA=1, SB=4, MW=1 -> mem[7]=0x0010. Then MD=1, RW=1, DR=5 -> R5=0x0010. PC=7 -> InstructIn=0x0010. Also RW+MW in the same cycle.
- Macro: with DATAPATH_R0_ZERO_EN, writing 0x1234 to DR=0 -> R0 reads 0. Without it -> R0 reads 0x1234.
